// File: rtl/lin_frame_reader.sv
// lin_frame_reader
//   Fetches a LIN response payload from the 32-bit word frame memory and
//   streams it out byte by byte to the LIN TX byte engine. Bytes are taken
//   little-endian from consecutive words starting at base_addr.
//
//   Optional feature macro: LIN_CHECKSUM_EN
//     defined   -> the classic checksum (inverted end-around-carry sum) is
//                  appended as byte n+1.
//     undefined -> exactly n payload bytes are sent.
//
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   start           one-cycle frame request, only looked at while idle
//   base_addr, len  word address of byte 0 and payload length (clamped to MAX_LEN)
//   rd_addr         registered memory read address
//   rd_data         memory read data (one edge of latency after rd_addr is sampled)
//   tx_byte/tx_valid/tx_ready  byte stream toward the transmitter
//   busy            frame in progress
//   done            one-cycle pulse at frame completion
module lin_frame_reader #(
  parameter int ADDR_W  = 32,
  parameter int MAX_LEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

`ifdef LIN_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, CSUM, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, FIN} state_t;
`endif

  // len is only 4 bits, so a MAX_LEN of 15 or more never clamps.
  localparam logic [3:0] MAX_N = (MAX_LEN > 15) ? 4'd15 : 4'(MAX_LEN);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       word_q, word_d;
  logic [3:0]        n_q, n_d;      // effective payload length
  logic [3:0]        idx_q, idx_d;  // index of the byte currently on tx_byte
`ifdef LIN_CHECKSUM_EN
  logic [7:0]        acc_q, acc_d;
`endif

  logic [3:0] n_eff;
  logic       accept;
  logic       last;

  assign n_eff  = (len > MAX_N) ? MAX_N : len;
  assign accept = tx_valid_q & tx_ready;
  assign last   = (idx_q == n_q - 4'd1);

  function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] l);
    return w[{l, 3'b000} +: 8];
  endfunction

`ifdef LIN_CHECKSUM_EN
  // 8-bit add with the carry folded back in; the folded result cannot carry again.
  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0] + {7'b0, s[8]};
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    word_d     = word_q;
    n_d        = n_q;
    idx_d      = idx_q;
`ifdef LIN_CHECKSUM_EN
    acc_d      = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_eff != 4'd0) begin
            n_d       = n_eff;
            idx_d     = 4'd0;
            rd_addr_d = base_addr;
            busy_d    = 1'b1;
`ifdef LIN_CHECKSUM_EN
            acc_d     = 8'd0;
`endif
            state_d   = FETCH;
          end else begin
            // Empty frame: busy and done would overlap in the same single
            // cycle, and busy falls while done is high, so only done shows.
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FIN;
          end
        end
      end
      FETCH: state_d = LOAD;  // memory samples rd_addr on this edge
      LOAD: begin
        word_d     = rd_data;
        tx_byte_d  = lane_sel(rd_data, idx_q[1:0]);
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (accept) begin
`ifdef LIN_CHECKSUM_EN
          acc_d = csum_add(acc_q, tx_byte_q);
`endif
          if (last) begin
`ifdef LIN_CHECKSUM_EN
            // Checksum goes out in the very next cycle.
            tx_byte_d  = ~acc_d;
            tx_valid_d = 1'b1;
            state_d    = CSUM;
`else
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = FIN;
`endif
          end else if (idx_q[1:0] == 2'd3) begin
            rd_addr_d  = rd_addr_q + 1'b1;
            idx_d      = idx_q + 4'd1;
            tx_valid_d = 1'b0;
            state_d    = FETCH;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_byte_d = lane_sel(word_q, idx_q[1:0] + 2'd1);
          end
        end
      end
`ifdef LIN_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = FIN;
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      tx_byte_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      word_q     <= 32'd0;
      n_q        <= 4'd0;
      idx_q      <= 4'd0;
`ifdef LIN_CHECKSUM_EN
      acc_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      word_q     <= word_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
`ifdef LIN_CHECKSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign rd_addr  = rd_addr_q;
  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lin_frame_reader.sv
// Directed bench for lin_frame_reader with a registered-read word memory.
module tb_lin_frame_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [3:0]  len;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  lin_frame_reader #(.ADDR_W(32), .MAX_LEN(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  always @(posedge clk) rd_data <= mem[rd_addr[3:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accepted bytes with the cycle in which they were on the bus.
  logic [7:0] got_b[$];
  int         got_s[$];
  int         done_cnt = 0;
  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready) begin
      got_b.push_back(tx_byte);
      got_s.push_back(cyc);
    end
    if (reset && done) done_cnt++;
  end

  int nchk = 0;
  int nerr = 0;
  int e0;
  int dc, dc0;
  logic [7:0] exp_b[16];
  int         exp_s[16];
  int         exp_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic exp_clear();
    exp_n = 0;
  endtask

  task automatic exp_push(input logic [7:0] b, input int s);
    exp_b[exp_n] = b;
    exp_s[exp_n] = s;
    exp_n++;
  endtask

  task automatic start_frame(input logic [31:0] b, input logic [3:0] l);
    got_b.delete();
    got_s.delete();
    start = 1'b1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(output int dcyc);
    bit found = 0;
    dcyc = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (done) begin found = 1; dcyc = cyc; end
    end
    if (!found) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_stream(input string tag, input bit with_stamp);
    chk({tag, "_cnt"}, got_b.size(), exp_n);
    for (int i = 0; i < exp_n && i < got_b.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), {24'd0, got_b[i]}, {24'd0, exp_b[i]});
      if (with_stamp) chk($sformatf("%s_t%0d", tag, i), got_s[i] - e0, exp_s[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; len = '0; tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'hEEEE_EEEE;
    mem[0] = 32'h4433_2211;
    repeat (2) @(posedge clk); #1;
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: one full word, back-to-back
    start_frame(32'd0, 4'd4);
    chk("t1_rd_addr", rd_addr, 0);
    chk("t1_busy", busy, 1);
    exp_clear();
    exp_push(8'h11, 2); exp_push(8'h22, 3); exp_push(8'h33, 4); exp_push(8'h44, 5);
`ifdef LIN_CHECKSUM_EN
    exp_push(8'h55, 6);
`endif
    wait_done(dc);
    check_stream("t1", 1'b1);
    chk("t1_done_cyc", dc - e0, exp_s[exp_n-1] + 1);
    chk("t1_busy_off", busy, 0);

    // 2: word boundary bubble and end-around carry
    mem[0] = 32'h0000_01FF; mem[1] = 32'h0000_0000;
    @(posedge clk); #1;
    start_frame(32'd0, 4'd5);
    chk("t2_rd_addr0", rd_addr, 0);
    exp_clear();
    exp_push(8'hFF, 2); exp_push(8'h01, 3); exp_push(8'h00, 4); exp_push(8'h00, 5);
    exp_push(8'h00, 8);
`ifdef LIN_CHECKSUM_EN
    exp_push(8'hFE, 9);
`endif
    wait_done(dc);
    check_stream("t2", 1'b1);
    chk("t2_done_cyc", dc - e0, exp_s[exp_n-1] + 1);
    chk("t2_rd_addr1", rd_addr, 1);

    // 3: len clamped to 8, words 2..3, word 4 must not be read out
    mem[2] = 32'h8382_8180; mem[3] = 32'h8786_8584;
    @(posedge clk); #1;
    start_frame(32'd2, 4'd12);
    exp_clear();
    for (int i = 0; i < 8; i++) exp_push(8'h80 + 8'(i), (i < 4) ? 2 + i : 4 + i);
`ifdef LIN_CHECKSUM_EN
    exp_push(8'hDF, 12);
`endif
    wait_done(dc);
    check_stream("t3", 1'b1);
    chk("t3_rd_addr", rd_addr, 3);

    // 4: stall for 5 cycles mid-word, start pulsed while busy
    mem[5] = 32'hDDCC_BBAA;
    @(posedge clk); #1;
    dc0 = done_cnt;
    start_frame(32'd5, 4'd4);
    repeat (3) begin @(posedge clk); #1; end
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_stall_v%0d", k), tx_valid, 1);
      chk($sformatf("t4_stall_b%0d", k), tx_byte, 8'hBB);
      start = (k == 0);
      base_addr = 32'd0; len = 4'd1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("t4_busy", busy, 1);
    tx_ready = 1'b1;
    exp_clear();
    exp_push(8'hAA, 0); exp_push(8'hBB, 0); exp_push(8'hCC, 0); exp_push(8'hDD, 0);
`ifdef LIN_CHECKSUM_EN
    exp_push(8'hEE, 0);
`endif
    wait_done(dc);
    repeat (4) begin @(posedge clk); #1; end
    check_stream("t4", 1'b0);
    chk("t4_done_cnt", done_cnt - dc0, 1);
    chk("t4_rd_addr", rd_addr, 5);
    chk("t4_idle", busy, 0);

    // 5: zero-length frame
    dc0 = done_cnt;
    start_frame(32'd9, 4'd0);
    chk("t5_done", done, 1);
    chk("t5_tx_valid", tx_valid, 0);
    chk("t5_rd_addr", rd_addr, 5);
    @(posedge clk); #1;
    chk("t5_done_off", done, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_nbytes", got_b.size(), 0);
    chk("t5_done_cnt", done_cnt - dc0, 1);

    // 6: reset during SEND, then a normal frame
    mem[0] = 32'h4433_2211;
    mem[6] = 32'h0403_0201;
    tx_ready = 1'b0;
    start_frame(32'd6, 4'd4);
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_pre_v", tx_valid, 1);
    chk("t6_pre_b", tx_byte, 8'h01);
    dc0 = done_cnt;
    reset = 1'b0;
    #1;
    chk("t6_rd_addr", rd_addr, 0);
    chk("t6_tx_byte", tx_byte, 0);
    chk("t6_tx_valid", tx_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tx_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_no_done", done_cnt - dc0, 0);
    start_frame(32'd0, 4'd4);
    exp_clear();
    exp_push(8'h11, 2); exp_push(8'h22, 3); exp_push(8'h33, 4); exp_push(8'h44, 5);
`ifdef LIN_CHECKSUM_EN
    exp_push(8'h55, 6);
`endif
    wait_done(dc);
    check_stream("t6", 1'b1);
    chk("t6_done_cyc", dc - e0, exp_s[exp_n-1] + 1);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
